// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - opcode, state and mux-select encodings for the multi-cycle control unit
package mc_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LI   = 6'b100111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_IEXEC  = 4'd9,
    ST_IWB    = 4'd10,
    ST_BRANCH = 4'd11,
    ST_JUMP   = 4'd12,
    ST_TRAP   = 4'd13
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_unit_opclass.sv
// rtl/mc_control_unit_opclass.sv - opcode to post-DECODE state decoder with li/bne/lw qualifiers
module mc_opclass
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output state_t     next_state,
  output logic       is_li,
  output logic       is_bne,
  output logic       is_lw
);

  always_comb begin
    next_state = ST_TRAP;
    case (opcode)
      OP_R:          next_state = ST_EXEC;
      OP_ADDI, OP_LI: next_state = ST_IEXEC;
      OP_LW, OP_SW:  next_state = ST_MEMADR;
      OP_BEQ, OP_BNE: next_state = ST_BRANCH;
      OP_J:          next_state = ST_JUMP;
      default:       next_state = ST_TRAP;
    endcase
  end

  assign is_li  = (opcode == OP_LI);
  assign is_bne = (opcode == OP_BNE);
  assign is_lw  = (opcode == OP_LW);

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle MIPS control FSM owning the instruction register
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT  = 1'b1,
  parameter bit TRAP_HALT = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic [5:0]       opcode,
  output logic [5:0]       funct,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [15:0]      imm,
  output logic [25:0]      jaddr,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic             alu_a_zero,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       state
);

  state_t           r_state;
  state_t           w_next;
  state_t           w_dec_next;
  logic [31:0]      r_ir;
  logic [CNT_W-1:0] r_err_cnt;
  logic             w_ready;
  logic             w_is_li;
  logic             w_is_bne;
  logic             w_is_lw;

  assign w_ready = MEM_WAIT ? mem_ready : 1'b1;

  mc_opclass u_opclass (
    .opcode     (r_ir[31:26]),
    .next_state (w_dec_next),
    .is_li      (w_is_li),
    .is_bne     (w_is_bne),
    .is_lw      (w_is_lw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir <= '0;
    end else if (ir_write) begin
      r_ir <= mem_rdata;
    end
  end

  // Counted on the DECODE->TRAP transition so a halted trap counts only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (r_state == ST_DECODE && w_dec_next == ST_TRAP && r_err_cnt != '1) begin
      r_err_cnt <= r_err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    w_next        = r_state;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_a_zero    = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_src        = PCSRC_ALU;
    alu_op        = ALU_ADD;
    illegal       = 1'b0;
    case (r_state)
      ST_IDLE: w_next = ST_FETCH;
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = w_ready;
        pc_write  = w_ready;
        if (w_ready) w_next = ST_DECODE;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        w_next    = w_dec_next;
      end
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = w_is_lw ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (w_ready) w_next = ST_MEMWB;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (w_ready) w_next = ST_FETCH;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        w_next    = ST_ALUWB;
      end
      ST_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        w_next    = ST_FETCH;
      end
      ST_IEXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_a_zero = w_is_li;
        w_next     = ST_IWB;
      end
      ST_IWB: begin
        reg_write = 1'b1;
        w_next    = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_src        = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
        branch_ne     = w_is_bne;
        w_next        = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
        w_next   = ST_FETCH;
      end
      ST_TRAP: begin
        illegal = 1'b1;
        w_next  = TRAP_HALT ? ST_TRAP : ST_FETCH;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign opcode  = r_ir[31:26];
  assign rs      = r_ir[25:21];
  assign rt      = r_ir[20:16];
  assign rd      = r_ir[15:11];
  assign shamt   = r_ir[10:6];
  assign funct   = r_ir[5:0];
  assign imm     = r_ir[15:0];
  assign jaddr   = r_ir[25:0];
  assign err_cnt = r_err_cnt;
  assign state   = r_state;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - self-checking bench for mc_control_unit (resume and halting trap variants)
module tb_mc_control_unit;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] jaddr;
  logic        ir_write, pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, alu_a_zero, illegal;
  logic [1:0]  alu_src_b, pc_src, alu_op;
  logic [7:0]  err_cnt;
  logic [3:0]  state;

  logic [5:0]  h_opcode, h_funct;
  logic [4:0]  h_rs, h_rt, h_rd, h_shamt;
  logic [15:0] h_imm;
  logic [25:0] h_jaddr;
  logic        h_ir_write, h_pc_write, h_pc_write_cond, h_branch_ne, h_i_or_d, h_mem_read, h_mem_write;
  logic        h_mem_to_reg, h_reg_dst, h_reg_write, h_alu_src_a, h_alu_a_zero, h_illegal;
  logic [1:0]  h_alu_src_b, h_pc_src, h_alu_op;
  logic [7:0]  h_err_cnt;
  logic [3:0]  h_state;

  mc_control_unit #(.MEM_WAIT(1'b1), .TRAP_HALT(1'b0), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm(imm), .jaddr(jaddr), .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_ne(branch_ne), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_a_zero(alu_a_zero), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_op(alu_op), .illegal(illegal), .err_cnt(err_cnt), .state(state)
  );

  mc_control_unit #(.MEM_WAIT(1'b1), .TRAP_HALT(1'b1), .CNT_W(8)) dut_h (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .opcode(h_opcode), .funct(h_funct), .rs(h_rs), .rt(h_rt), .rd(h_rd), .shamt(h_shamt),
    .imm(h_imm), .jaddr(h_jaddr), .ir_write(h_ir_write), .pc_write(h_pc_write),
    .pc_write_cond(h_pc_write_cond), .branch_ne(h_branch_ne), .i_or_d(h_i_or_d),
    .mem_read(h_mem_read), .mem_write(h_mem_write), .mem_to_reg(h_mem_to_reg),
    .reg_dst(h_reg_dst), .reg_write(h_reg_write), .alu_src_a(h_alu_src_a),
    .alu_a_zero(h_alu_a_zero), .alu_src_b(h_alu_src_b), .pc_src(h_pc_src),
    .alu_op(h_alu_op), .illegal(h_illegal), .err_cnt(h_err_cnt), .state(h_state)
  );

  always #5 clk = ~clk;

  wire [18:0] w_ctrl = {ir_write, pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
                        mem_to_reg, reg_dst, reg_write, alu_src_a, alu_a_zero, alu_src_b, pc_src,
                        alu_op, illegal};
  wire [18:0] w_h_ctrl = {h_ir_write, h_pc_write, h_pc_write_cond, h_branch_ne, h_i_or_d, h_mem_read,
                          h_mem_write, h_mem_to_reg, h_reg_dst, h_reg_write, h_alu_src_a, h_alu_a_zero,
                          h_alu_src_b, h_pc_src, h_alu_op, h_illegal};
  wire [31:0] w_fields   = {opcode, rs, rt, rd, shamt, funct};
  wire [31:0] w_h_fields = {h_opcode, h_rs, h_rt, h_rd, h_shamt, h_funct};

  int checks = 0;
  int errors = 0;
  int cnt    = 0;   // expected err_cnt, resume variant
  int h_cnt  = 0;   // expected err_cnt, halting variant
  bit h_mode = 1'b0; // halting variant is parked in TRAP

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Control table: each state lists the controls it raises; everything else is 0.
  function automatic logic [18:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op, input logic rdy);
    logic irw, pcw, pwc, bne, iod, mr, mw, m2r, rdst, rw, sa, az, ill;
    logic [1:0] sb, ps, ao;
    {irw, pcw, pwc, bne, iod, mr, mw, m2r, rdst, rw, sa, az, ill} = '0;
    sb = 2'b00; ps = 2'b00; ao = 2'b00;
    case (st)
      ST_FETCH:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      ST_DECODE: sb = 2'b11;
      ST_MEMADR: begin sa = 1; sb = 2'b10; end
      ST_MEMRD:  begin mr = 1; iod = 1; end
      ST_MEMWB:  begin rw = 1; m2r = 1; end
      ST_MEMWR:  begin mw = 1; iod = 1; end
      ST_EXEC:   begin sa = 1; ao = 2'b10; end
      ST_ALUWB:  begin rw = 1; rdst = 1; end
      ST_IEXEC:  begin sa = 1; sb = 2'b10; az = (op == 6'b100111); end
      ST_IWB:    rw = 1;
      ST_BRANCH: begin sa = 1; ao = 2'b01; ps = 2'b01; pwc = 1; bne = (op == 6'b000101); end
      ST_JUMP:   begin pcw = 1; ps = 2'b10; end
      ST_TRAP:   ill = 1;
      default:   ;
    endcase
    return {irw, pcw, pwc, bne, iod, mr, mw, m2r, rdst, rw, sa, az, sb, ps, ao, ill};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h08, 6'h27, 6'h23, 6'h2B, 6'h02, 6'h04, 6'h05};
  endfunction

  function automatic logic rbit();
    return 1'($urandom % 2);
  endfunction

  task automatic cyc(input logic [3:0] st, input logic rdy, input logic [31:0] rdata, input logic [5:0] op);
    @(negedge clk);
    mem_ready = rdy;
    mem_rdata = rdata;
    #1;
    chk("state", 32'(state), 32'(st));
    chk("ctrl", 32'(w_ctrl), 32'(exp_ctrl(st, op, rdy)));
    chk("err_cnt", 32'(err_cnt), cnt);
    if (h_mode) begin
      chk("halt_state", 32'(h_state), 32'(ST_TRAP));
      chk("halt_ctrl", 32'(w_h_ctrl), 32'(exp_ctrl(ST_TRAP, op, rdy)));
    end else begin
      chk("halt_state", 32'(h_state), 32'(st));
      chk("halt_ctrl", 32'(w_h_ctrl), 32'(exp_ctrl(st, op, rdy)));
    end
    chk("halt_err_cnt", 32'(h_err_cnt), h_cnt);
  endtask

  // One instruction: wf fetch wait cycles, wm data-access wait cycles.
  task automatic do_instr(input logic [31:0] ins, input int wf, input int wm);
    logic [5:0] op;
    op = ins[31:26];
    for (int i = 0; i < wf; i++) cyc(ST_FETCH, 1'b0, ins, op);
    cyc(ST_FETCH, 1'b1, ins, op);
    cyc(ST_DECODE, rbit(), $urandom(), op);
    chk("ir_fields", w_fields, ins);
    chk("imm", 32'(imm), 32'(ins[15:0]));
    chk("jaddr", 32'(jaddr), 32'(ins[25:0]));
    if (!h_mode) chk("halt_ir_fields", w_h_fields, ins);
    case (op)
      6'h00: begin cyc(ST_EXEC, rbit(), $urandom(), op); cyc(ST_ALUWB, rbit(), $urandom(), op); end
      6'h08, 6'h27: begin cyc(ST_IEXEC, rbit(), $urandom(), op); cyc(ST_IWB, rbit(), $urandom(), op); end
      6'h23: begin
        cyc(ST_MEMADR, rbit(), $urandom(), op);
        for (int i = 0; i < wm; i++) cyc(ST_MEMRD, 1'b0, $urandom(), op);
        cyc(ST_MEMRD, 1'b1, $urandom(), op);
        cyc(ST_MEMWB, rbit(), $urandom(), op);
      end
      6'h2B: begin
        cyc(ST_MEMADR, rbit(), $urandom(), op);
        for (int i = 0; i < wm; i++) cyc(ST_MEMWR, 1'b0, $urandom(), op);
        cyc(ST_MEMWR, 1'b1, $urandom(), op);
      end
      6'h04, 6'h05: cyc(ST_BRANCH, rbit(), $urandom(), op);
      6'h02: cyc(ST_JUMP, rbit(), $urandom(), op);
      default: begin
        if (cnt < 255) cnt++;
        if (!h_mode) begin
          h_mode = 1'b1;
          if (h_cnt < 255) h_cnt++;
        end
        cyc(ST_TRAP, rbit(), $urandom(), op);
      end
    endcase
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_after_release", 32'(state), 32'(ST_IDLE));
    chk("idle_ctrl", 32'(w_ctrl), 0);
  endtask

  task automatic check_reset_state();
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    chk("rst_ctrl", 32'(w_ctrl), 0);
    chk("rst_fields", w_fields, 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_halt_state", 32'(h_state), 32'(ST_IDLE));
    chk("rst_halt_err_cnt", 32'(h_err_cnt), 0);
  endtask

  initial begin
    logic [31:0] ins;
    logic [5:0]  op;
    int          k;

    // Reset held with live memory traffic.
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_state();
    release_reset();

    // Directed instructions.
    do_instr(32'h012A4020, 0, 0);
    chk("rtype_rd", 32'(rd), 8);
    chk("rtype_funct", 32'(funct), 32'h20);
    do_instr(32'h8D090004, 0, 2);
    chk("lw_imm", 32'(imm), 32'h0004);
    do_instr(32'h15090003, 0, 0);
    do_instr(32'h11090003, 0, 0);
    do_instr(32'h9C0800FF, 0, 0);
    do_instr(32'hAD0A0010, 1, 1);
    do_instr(32'h08000123, 2, 0);

    // Illegal opcode: resume variant returns to FETCH, halting variant parks in TRAP.
    do_instr(32'hFC000000, 0, 0);
    do_instr(32'h012A4020, 0, 0);
    do_instr(32'h8D090004, 1, 0);

    // Reset during a store stall.
    cyc(ST_FETCH, 1'b1, 32'hAD0A0010, 6'h2B);
    cyc(ST_DECODE, 1'b1, 32'h0, 6'h2B);
    cyc(ST_MEMADR, 1'b1, 32'h0, 6'h2B);
    cyc(ST_MEMWR, 1'b0, 32'h0, 6'h2B);
    rst_n = 1'b0;
    #1;
    cnt = 0; h_cnt = 0; h_mode = 1'b0;
    chk("rst_stall_mem_write", 32'(mem_write), 0);
    check_reset_state();
    release_reset();

    // Randomized instruction mix.
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 8);
      case (k)
        0: op = 6'h00; 1: op = 6'h08; 2: op = 6'h27; 3: op = 6'h23; 4: op = 6'h2B;
        5: op = 6'h04; 6: op = 6'h05; 7: op = 6'h02;
        default: begin
          op = 6'($urandom);
          while (is_legal(op)) op = 6'($urandom);
        end
      endcase
      ins = {op, 26'($urandom)};
      do_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Saturation of the error counter.
    for (int n = 0; n < 300; n++) do_instr(32'hFC000000 | 32'($urandom_range(0, 1023)), 0, 0);
    chk("err_cnt_saturated", 32'(err_cnt), 255);
    do_instr(32'h012A4020, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
